// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// KEYMAP is indexed by {col, row}; scan results carry a hit bit above the code.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  localparam int RES_W = 5;
  localparam int RES_HIT = 4;
  localparam logic [RES_W-1:0] RES_NONE = '0;

  function automatic logic [RES_W-1:0] res_key(
    input logic [3:0] k
  );
    return {1'b1, k};
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column strobe, row synchronizer and per-scan key decode.
// Multiple simultaneous keys collapse to an empty result to reject ghosts.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       scan_done,
  output logic [3:0] scan_key,
  output logic       scan_hit
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div;
  logic [1:0] cidx;
  logic [3:0] s1, s2;
  logic acc_any, acc_multi;
  logic [3:0] acc_key;
  logic [RES_W-1:0] res;

  logic [3:0] pressed;
  logic col_any, col_multi;
  logic [1:0] col_row;
  logic first;
  logic any_n, multi_n;
  logic [3:0] key_n;
  logic sample;

  always_comb begin
    pressed = ~s2;
    col_any = |pressed;
    col_multi = (pressed & (pressed - 4'd1)) != 4'd0;
    col_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pressed[i]) col_row = 2'(i);
    end
    first = (cidx == 2'd0);
    sample = (div == LAST);
    any_n = col_any | (acc_any & ~first);
    multi_n = col_multi
            | (~first & acc_multi)
            | (~first & acc_any & col_any);
    key_n = col_any ? KEYMAP[{cidx, col_row}] : acc_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      cidx <= 2'd0;
      col <= 4'b1110;
      s1 <= 4'hF;
      s2 <= 4'hF;
      acc_any <= 1'b0;
      acc_multi <= 1'b0;
      acc_key <= 4'h0;
      scan_done <= 1'b0;
      res <= RES_NONE;
    end else begin
      s1 <= row;
      s2 <= s1;
      scan_done <= 1'b0;
      if (sample) begin
        div <= '0;
        cidx <= cidx + 2'd1;
        col <= ~(4'b0001 << (cidx + 2'd1));
        acc_any <= any_n;
        acc_multi <= multi_n;
        acc_key <= key_n;
        if (cidx == 2'd3) begin
          scan_done <= 1'b1;
          res <= (any_n & ~multi_n) ? res_key(key_n) : RES_NONE;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  assign scan_hit = res[RES_HIT];
  assign scan_key = res[3:0];

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: debounced 4x4 keypad front end with a 4-digit history.
// A press is accepted after DEBOUNCE_SCANS matching scans; release likewise.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam logic [15:0] DB = 16'(DEBOUNCE_SCANS);

  logic scan_done, scan_hit;
  logic [3:0] scan_key;
  state_t state;
  logic [3:0] cand;
  logic [15:0] cnt, cnt_inc;
  logic accept;

  keypad_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .scan_done(scan_done),
    .scan_key(scan_key),
    .scan_hit(scan_hit)
  );

  always_comb begin
    cnt_inc = cnt + 16'd1;
    accept = 1'b0;
    if (scan_done && scan_hit) begin
      if (state == IDLE && DB == 16'd1) accept = 1'b1;
      if (state == DEBOUNCE && scan_key == cand && cnt_inc == DB)
        accept = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cand <= 4'h0;
      cnt <= 16'd0;
      key <= 4'h0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      digits <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        key_valid <= 1'b1;
        key <= scan_key;
        digits <= clr ? {12'h000, scan_key} : {digits[11:0], scan_key};
      end else if (clr) begin
        digits <= 16'h0000;
      end
      if (scan_done) begin
        unique case (state)
          IDLE: if (scan_hit) begin
            cand <= scan_key;
            cnt <= 16'd1;
            if (accept) begin
              state <= PRESSED;
              key_held <= 1'b1;
            end else begin
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!scan_hit) begin
              state <= IDLE;
              cnt <= 16'd0;
            end else if (scan_key != cand) begin
              cand <= scan_key;
              cnt <= 16'd1;
            end else if (accept) begin
              state <= PRESSED;
              key_held <= 1'b1;
              cnt <= 16'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRESSED: if (!scan_hit) begin
            cnt <= 16'd1;
            if (DB == 16'd1) begin
              state <= IDLE;
              key_held <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (scan_hit) begin
              state <= PRESSED;
              cnt <= 16'd0;
            end else if (cnt_inc >= DB) begin
              state <= IDLE;
              key_held <= 1'b0;
              cnt <= 16'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad stimulus with a queued scoreboard.
// A keypad model pulls a row low while its key is pressed and its column driven.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] row;
  logic clr = 1'b0;
  logic [3:0] col;
  logic [3:0] key;
  logic key_valid;
  logic key_held;
  logic [15:0] digits;

  logic [15:0] keys = 16'h0;

  typedef struct packed {
    logic [3:0] k;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_push = 0;

  localparam int K1 = 0, K2 = 4, K3 = 8, KA = 12;
  localparam int K5 = 5, K7 = 2, K9 = 10;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .clr(clr),
    .col(col),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held),
    .digits(digits)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] k, input logic [15:0] d);
    exp_t e;
    e.k = k;
    e.d = d;
    q.push_back(e);
    n_push++;
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic tap(input int idx);
    keys[idx] = 1'b1;
    scans(4);
    keys[idx] = 1'b0;
    scans(4);
  endtask

  // Monitor: every accepted press must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      exp_t e;
      n_valid++;
      if (q.size() == 0) begin
        chk("unexpected_key_valid", {28'h0, key}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("key", {28'h0, key}, {28'h0, e.k});
        chk("digits", {16'h0, digits}, {16'h0, e.d});
        chk("held_with_valid", {31'h0, key_held}, 32'h1);
      end
    end
  end

  initial begin
    int waited;
    #12;
    chk("rst_col", {28'h0, col}, 32'hE);
    chk("rst_key", {28'h0, key}, 32'h0);
    chk("rst_valid", {31'h0, key_valid}, 32'h0);
    chk("rst_held", {31'h0, key_held}, 32'h0);
    chk("rst_digits", {16'h0, digits}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    waited = 0;
    while (col == 4'b1110 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("col_first_step", {28'h0, col}, 32'hD);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((1 + i / 4) % 4));
      chk("col_seq", {28'h0, col}, {28'h0, ec});
      @(negedge clk);
    end
    scans(2);
    chk("idle_digits", {16'h0, digits}, 32'h0);

    expect_key(4'h5, 16'h0005);
    keys[K5] = 1'b1;
    scans(5);
    keys[K5] = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_after_release", {31'h0, key_held}, 32'h1);
    repeat (44) @(negedge clk);
    chk("held_fall", {31'h0, key_held}, 32'h0);
    scans(2);

    expect_key(4'h1, 16'h0051);
    tap(K1);
    expect_key(4'h2, 16'h0512);
    tap(K2);
    expect_key(4'h3, 16'h5123);
    tap(K3);
    expect_key(4'hA, 16'h123A);
    tap(KA);
    chk("digits_123A", {16'h0, digits}, 32'h123A);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("digits_clr", {16'h0, digits}, 32'h0);

    keys[K7] = 1'b1;
    scans(1);
    keys[K7] = 1'b0;
    scans(1);
    keys[K7] = 1'b1;
    scans(1);
    keys[K7] = 1'b0;
    scans(2);
    chk("bounce_no_valid", n_valid, 5);
    expect_key(4'h7, 16'h0007);
    keys[K7] = 1'b1;
    scans(3);
    keys[K7] = 1'b0;
    scans(4);

    keys[K1] = 1'b1;
    keys[K2] = 1'b1;
    scans(4);
    chk("multi_no_valid", n_valid, 6);
    expect_key(4'h1, 16'h0071);
    keys[K2] = 1'b0;
    scans(4);
    keys[K1] = 1'b0;
    scans(4);

    expect_key(4'h9, 16'h0719);
    keys[K9] = 1'b1;
    scans(4);
    chk("nine_held", {31'h0, key_held}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_col", {28'h0, col}, 32'hE);
    chk("mid_rst_key", {28'h0, key}, 32'h0);
    chk("mid_rst_held", {31'h0, key_held}, 32'h0);
    chk("mid_rst_digits", {16'h0, digits}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    expect_key(4'h9, 16'h0009);
    scans(4);
    keys[K9] = 1'b0;
    scans(4);
    chk("final_digits", {16'h0, digits}, 32'h0009);

    chk("queue_drained", q.size(), 0);
    chk("valid_count", n_valid, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex keypad on a Pmod header and delivers debounced key presses to the matrix multiplier's entry logic. It is the input-side counterpart of the multiplexed seven-segment display path: columns are strobed the same way anodes are. The last four keys are kept as a 16-bit hex word that can drive the display's 16-bit digit input directly, so the operator sees what was typed.

## Interface

Parameters:
- SCAN_DIV, 100000: clock cycles each column is driven (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows; pulled up, low means pressed. Asynchronous to clk.
- clr  in  1  synchronous clear of `digits`.
- col  out  4  column drive, active-low, exactly one bit low at any time.
- key  out  4  hex code of the last accepted key.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high while the accepted key is still considered down.
- digits  out  16  last four accepted keys; newest key in [3:0].

## Operation

- Keymap, listed by column for rows 0..3:
  - col0 = 1, 4, 7, 0
  - col1 = 2, 5, 8, F
  - col2 = 3, 6, 9, E
  - col3 = A, B, C, D
- Scan sequence: col0, col1, col2, col3, then repeat. One full scan takes 4*SCAN_DIV cycles.
- Rows pass through a 2-FF synchronizer.
- Rows are sampled on the last dwell cycle of each column.
- Scan result, formed at the end of col3's dwell:
  - NONE if no key is down.
  - KEY(k) if exactly one key is down.
  - NONE if two or more keys are down (ghosting rejection).
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. A counter `cnt` counts scans.
  - IDLE: on KEY(k), set cand=k, cnt=1, go to DEBOUNCE.
  - DEBOUNCE, result KEY(cand): increment cnt. When cnt reaches DEBOUNCE_SCANS, go to PRESSED and accept the key.
  - DEBOUNCE, result KEY(j) with j≠cand: set cand=j, cnt=1.
  - DEBOUNCE, result NONE: go to IDLE.
  - PRESSED: on NONE, set cnt=1 and go to RELEASE. Any KEY result keeps PRESSED; there is no auto-repeat, and a key change while held is ignored.
  - RELEASE, result NONE: increment cnt. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
  - RELEASE, result KEY: go back to PRESSED without a new acceptance.
- DEBOUNCE_SCANS=1: a single-scan press is accepted immediately, going straight from IDLE to PRESSED.
- Acceptance happens at one clock edge:
  - key_valid=1 for one cycle;
  - key=cand;
  - digits={digits[11:0], cand}.
- key_held=1 in PRESSED and RELEASE, 0 otherwise.
- clr: digits=0 on the next edge.
- clr and acceptance in the same cycle: acceptance wins, digits={12'h000, cand}.
- Reset values, applied asynchronously: col=4'b1110, key=0, key_valid=0, key_held=0, digits=0, FSM=IDLE, all counters=0, synchronizer flops=4'b1111.
- Reset mid-operation aborts any press. A key still held after reset deasserts must be debounced anew and produces a fresh key_valid.

## Timing

- col changes on the edge where the dwell counter wraps from SCAN_DIV-1 to 0.
- Row sampling happens SCAN_DIV-1 cycles after a column change. With SCAN_DIV≥4 this leaves at least 2 synchronizer cycles plus 1 cycle of settling.
- The scan result is registered one cycle after the col3 sample. The FSM acts on it the following cycle.
- Press latency: key_valid asserts no later than (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 4 cycles after stable row contact.
- The minimum interval between two key_valid pulses is 2*DEBOUNCE_SCANS scans.

## Structure

- Package `keypad_pkg` holds:
  - the FSM state enum;
  - the KEYMAP constant, indexed by {col, row};
  - scan-result encoding localparams (valid bit + 4-bit code).
- Sub-module `keypad_col_scan` owns:
  - the dwell counter and column strobe;
  - the row synchronizer and per-column sampling;
  - multi-key detection.
  - It outputs `scan_done` (a pulse) plus `scan_key` / `scan_hit`.
- The top level holds the debounce FSM, `cnt`, and the output registers.

## Test plan

Bench runs with SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan is 16 cycles. A keypad model pulls the row low while its column is low.

- Reset, no keys: col=1110, then cycles 1101, 1011, 0111 every 4 cycles. key_valid is never asserted and digits=0x0000.
- Hold '5' (col1/row1) for 5 scans, then release: exactly one key_valid, key=5, digits=0x0005. key_held rises with key_valid and falls 2 scans after release.
- Press and release 1, 2, 3, A in turn: digits=0x123A, exactly four key_valid pulses. Asserting clr then gives digits=0x0000.
- Bounce: '7' present for 1 scan, absent for 1 scan, present for 1 scan: no key_valid. Holding '7' for 2 scans afterwards gives key=7.
- Multi-key: '1' and '2' held for 4 scans gives no key_valid. Release '2' while keeping '1': key_valid with key=1 after 2 scans.
- Assert rst while '9' is in PRESSED: all outputs clear immediately. Keep '9' held after rst deasserts: a new key_valid with key=9, and digits=0x0009.
